// File: rtl/instr_loader.sv
// instr_loader: accepts decoded instruction fields, range-checks them, packs
// each into a 32-bit word and writes it into the processor Z instruction RAM
// through the processor's load port. Asserts working once the last word lands.
//
// Handshake: a field set transfers on a rising clock edge where
// in_valid && in_ready are both 1. in_ready is registered and is only high
// in LOAD, so at most one transfer happens per write cycle. The source may
// hold in_valid high indefinitely; nothing is consumed while in_ready is low.
module instr_loader #(
    parameter int ADDR_W    = 9,
    parameter int ADDR_STEP = 4,
    parameter int MAX_WORDS = 128
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [3:0]        in_rA,
    input  logic [3:0]        in_rB,
    input  logic [15:0]       in_valC,
    input  logic              in_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wEn,
    output logic [31:0]       mem_wDat,
    output logic              working,
    output logic [7:0]        count,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WR   = 3'd2,
        HOLD = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);
    localparam logic [7:0]        MAX_CNT = 8'(MAX_WORDS);

    localparam logic [1:0] CODE_FUNC = 2'd1;
    localparam logic [1:0] CODE_REG  = 2'd2;
    localparam logic [1:0] CODE_OVF  = 2'd3;

    state_t state;
    logic   last_q;
    logic   bad_func;
    logic   bad_reg;

    assign state_dbg = state;

    // Legality of the presented field set: IRMOV and the four OP functions only.
    always_comb begin
        bad_func = 1'b1;
        bad_reg  = 1'b0;
        case (in_icode)
            4'h3: begin
                bad_func = (in_ifun != 4'h0);
                bad_reg  = (in_rA != 4'hF) || (in_rB > 4'd5);
            end
            4'h6: begin
                bad_func = (in_ifun > 4'd3);
                bad_reg  = (in_rA > 4'd5) || (in_rB > 4'd5);
            end
            default: ;
        endcase
    end

    // Session FSM with all load-port and status outputs registered.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            last_q   <= 1'b0;
            in_ready <= 1'b0;
            mem_addr <= '0;
            mem_wEn  <= 1'b0;
            mem_wDat <= '0;
            working  <= 1'b0;
            count    <= '0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        state    <= LOAD;
                        mem_addr <= base_addr;
                        count    <= '0;
                        err      <= 1'b0;
                        err_code <= '0;
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        // Illegal words are rejected even when flagged last.
                        if (bad_func) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= CODE_FUNC;
                        end else if (bad_reg) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= CODE_REG;
                        end else if (count == MAX_CNT) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= CODE_OVF;
                        end else begin
                            state    <= WR;
                            mem_wDat <= {in_icode, in_ifun, in_rA, in_rB, in_valC};
                            last_q   <= in_last;
                            mem_wEn  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    state   <= HOLD;
                    mem_wEn <= 1'b0;
                end
                HOLD: begin
                    // The processor registers wEn, so the write lands at the
                    // end of this cycle; only then advance the address.
                    count    <= count + 8'd1;
                    mem_addr <= mem_addr + STEP;
                    if (last_q) begin
                        state   <= RUN;
                        working <= 1'b1;
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        working <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    mem_wEn  <= 1'b0;
                    working  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a default-size instance and a
// MAX_WORDS=2 instance share stimulus; write pulses of the default instance
// are checked against an expected queue of {addr, data}.
module tb_instr_loader;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [8:0]  base_addr;
    logic        stop;
    logic        in_valid;
    logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
    logic [15:0] in_valC;
    logic        in_last;

    logic        in_ready, mem_wEn, working, err;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wDat;
    logic [7:0]  count;
    logic [1:0]  err_code;
    logic [2:0]  state_dbg;

    logic        s_in_ready, s_mem_wEn, s_working, s_err;
    logic [8:0]  s_mem_addr;
    logic [31:0] s_mem_wDat;
    logic [7:0]  s_count;
    logic [1:0]  s_err_code;
    logic [2:0]  s_state_dbg;

    int total = 0;
    int bad   = 0;
    int s_wen_cnt = 0;

    logic [40:0] exp_q[$];

    instr_loader dut (
        .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr),
        .stop(stop), .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC), .in_last(in_last), .mem_addr(mem_addr),
        .mem_wEn(mem_wEn), .mem_wDat(mem_wDat), .working(working),
        .count(count), .err(err), .err_code(err_code), .state_dbg(state_dbg)
    );

    instr_loader #(.MAX_WORDS(2)) dut_small (
        .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr),
        .stop(stop), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC), .in_last(in_last), .mem_addr(s_mem_addr),
        .mem_wEn(s_mem_wEn), .mem_wDat(s_mem_wDat), .working(s_working),
        .count(s_count), .err(s_err), .err_code(s_err_code),
        .state_dbg(s_state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write pulse must match the head of exp_q
    always @(negedge clock) begin
        if (mem_wEn) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_addr, mem_wDat}, 41'h0);
            end else begin
                chk("write", {mem_addr, mem_wDat}, exp_q.pop_front());
            end
        end
        if (mem_wEn && working) chk("wen_and_working", 1, 0);
        if (s_mem_wEn) s_wen_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [8:0] base);
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // present one field set and return right after the accepting edge
    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [15:0] vc, input logic lst);
        int n;
        in_icode = ic; in_ifun = fn; in_rA = ra; in_rB = rb; in_valC = vc; in_last = lst;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        int snap;
        resetn = 1'b0; start = 1'b0; base_addr = '0; stop = 1'b0;
        in_valid = 1'b0; in_icode = '0; in_ifun = '0; in_rA = '0; in_rB = '0;
        in_valC = '0; in_last = 1'b0;
        tick(); tick();
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdat", mem_wDat, 0);
        chk("rst_wen", mem_wEn, 0);
        chk("rst_working", working, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_state", state_dbg, S_IDLE);
        resetn = 1'b1;

        // in_valid outside LOAD is ignored
        in_valid = 1'b1; in_icode = 4'h3; in_rA = 4'hF;
        tick(); tick();
        in_valid = 1'b0;
        chk("idle_ignores_valid", state_dbg, S_IDLE);

        // 1: single IRMOV with last
        do_start(9'h000);
        chk("t1_load", {state_dbg, in_ready}, {S_LOAD, 1'b1});
        exp_q.push_back({9'h000, 32'h30F21234});
        send(4'h3, 4'h0, 4'hF, 4'h2, 16'h1234, 1'b1);
        chk("t1_wr", {state_dbg, mem_wEn, working, in_ready}, {S_WR, 3'b100});
        tick();
        chk("t1_hold", {state_dbg, mem_wEn, mem_addr}, {S_HOLD, 1'b0, 9'h000});
        tick();
        chk("t1_run", {state_dbg, working, mem_wEn}, {S_RUN, 2'b10});
        chk("t1_count", count, 1);
        chk("t1_addr", mem_addr, 9'h004);
        do_start(9'h1F0);
        chk("run_ignores_start", state_dbg, S_RUN);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t1_stop", {state_dbg, working}, {S_IDLE, 1'b0});

        // 2: three OPs from 0x10
        do_start(9'h010);
        do_start(9'h100);
        chk("load_ignores_start", mem_addr, 9'h010);
        exp_q.push_back({9'h010, 32'h60130000});
        exp_q.push_back({9'h014, 32'h61050000});
        exp_q.push_back({9'h018, 32'h63440000});
        send(4'h6, 4'h0, 4'h1, 4'h3, 16'h0000, 1'b0);
        send(4'h6, 4'h1, 4'h0, 4'h5, 16'h0000, 1'b0);
        send(4'h6, 4'h3, 4'h4, 4'h4, 16'h0000, 1'b1);
        tick(); tick();
        chk("t2_run", {state_dbg, working}, {S_RUN, 1'b1});
        chk("t2_count", count, 3);
        chk("t2_addr", mem_addr, 9'h01C);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // 3: bad icode, flagged last -> ERR not RUN
        do_start(9'h000);
        send(4'h7, 4'h0, 4'hF, 4'hF, 16'h0, 1'b1);
        chk("t3_err", {state_dbg, err, err_code}, {S_ERR, 1'b1, 2'd1});
        chk("t3_outs", {mem_wEn, working, in_ready}, 3'b000);
        tick(); tick();
        chk("t3_sticky", {state_dbg, err, err_code}, {S_ERR, 1'b1, 2'd1});
        do_start(9'h000);
        chk("t3_restart", {state_dbg, err, err_code}, {S_LOAD, 1'b0, 2'd0});

        // 4: register and function range errors
        send(4'h6, 4'h0, 4'h6, 4'h0, 16'h0, 1'b0);
        chk("t4_op_ra6", err_code, 2);
        do_start(9'h000);
        send(4'h3, 4'h0, 4'h1, 4'h2, 16'h0, 1'b0);
        chk("t4_irmov_ra1", err_code, 2);
        do_start(9'h000);
        send(4'h6, 4'h0, 4'h1, 4'h6, 16'h0, 1'b0);
        chk("t4_op_rb6", err_code, 2);
        do_start(9'h000);
        send(4'h6, 4'h4, 4'h1, 4'h2, 16'h0, 1'b0);
        chk("t4_op_ifun4", err_code, 1);
        do_start(9'h000);
        send(4'h3, 4'h1, 4'hF, 4'h2, 16'h0, 1'b0);
        chk("t4_irmov_ifun1", err_code, 1);

        // 5: overflow on the MAX_WORDS=2 instance
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        snap = s_wen_cnt;
        do_start(9'h000);
        exp_q.push_back({9'h000, 32'h60120001});
        exp_q.push_back({9'h004, 32'h60230002});
        exp_q.push_back({9'h008, 32'h60340003});
        send(4'h6, 4'h0, 4'h1, 4'h2, 16'h0001, 1'b0);
        send(4'h6, 4'h0, 4'h2, 4'h3, 16'h0002, 1'b0);
        send(4'h6, 4'h0, 4'h3, 4'h4, 16'h0003, 1'b0);
        chk("t5_small_err", {s_state_dbg, s_err, s_err_code}, {S_ERR, 1'b1, 2'd3});
        tick(); tick();
        chk("t5_small_wen", s_wen_cnt - snap, 2);
        chk("t5_small_count", s_count, 2);
        chk("t5_main_count", {state_dbg, count}, {S_LOAD, 8'd3});

        // 6: reset during HOLD
        exp_q.push_back({9'h00C, 32'h30F5BEEF});
        send(4'h3, 4'h0, 4'hF, 4'h5, 16'hBEEF, 1'b1);
        tick();
        chk("t6_in_hold", state_dbg, S_HOLD);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("t6_rst", {state_dbg, mem_wEn, working}, {S_IDLE, 2'b00});
        chk("t6_count", count, 0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
